debug_hex_overlay: RTL and testbench
====================================

Name: debug_hex_overlay

Overview:
- Parametrised on-screen debug readout for the arcade cores.
- Renders NUM_CH channels of DATA_W-bit values as rows of hex text at a fixed screen origin.
- Values are captured once per frame, and a row is highlighted for a number of frames after its value changes.
- Sits between the core video generator and the MiSTer video output. Glyph bitmaps come from an external 8x8 font ROM.

Parameters:
- NUM_CH, 8, number of debug channels (1..16); one text row per channel.
- DATA_W, 16, bits per channel (multiple of 4, 4..64). DIGITS = DATA_W/4.
- X0, 16, left pixel column of the text box.
- Y0, 16, top line of the text box.
- HILITE_FRAMES, 60, frames a changed row stays highlighted (1..255).

Ports:
- clk  in  1  pixel-domain clock
- i_rst_n  in  1  asynchronous active-low reset
- i_ce_pix  in  1  pixel clock enable; the pipeline advances only when this is 1
- i_h  in  12  current horizontal pixel position
- i_v  in  12  current vertical line
- i_vblank  in  1  vertical blank
- i_freeze  in  1  1 = hold the captured values
- i_debug  in  NUM_CH*DATA_W  channel c occupies bits [c*DATA_W +: DATA_W]
- i_rgb  in  6  background video {r[1:0],g[1:0],b[1:0]}
- o_font_addr  out  11  {char_code[7:0], glyph_row[2:0]}
- i_font_bits  in  8  glyph row; valid 1 clk after o_font_addr; bit7 = leftmost pixel
- o_r, o_g, o_b  out  2 each  output colour
- o_active  out  1  current output pixel lies inside the text box

Behaviour:
- Reset:
  - All outputs 0; o_font_addr 0.
  - Shadow registers, highlight counters, vblank edge register and pipeline valid flags all 0.
  - Asserting reset mid-frame forces outputs to 0 at once; normal output resumes after 2 enabled pixels.
- Frame capture, on the clk where i_vblank rises (registered edge detect):
  - If i_freeze = 0: for each channel c, shadow[c] <= slice c of i_debug.
  - If the new value differs from the old shadow, hl_cnt[c] <= HILITE_FRAMES (reloads even if nonzero).
  - Otherwise, if hl_cnt[c] > 0, it decrements by 1.
  - If i_freeze = 1 on that clk: shadows and counters are unchanged. Freeze wins over capture.
- Text layout:
  - rx = i_h - X0, ry = i_v - Y0, using unsigned 12-bit compares.
  - in_box when i_h >= X0, rx < (DIGITS+2)*8, i_v >= Y0 and ry < NUM_CH*8.
  - Row: ch = ry[6:3]. Glyph row = ry[2:0]. Character column: cc = rx >> 3. Pixel within glyph: px = rx[2:0].
- Character codes:
  - cc = 0: hex of ch.
  - cc = 1: 8'h3A (':').
  - cc >= 2: nibble (DIGITS-1-(cc-2)) of shadow[ch], most significant nibble first.
  - Hex mapping: 0-9 -> 8'h30+n; A-F -> 8'h41+(n-10).
- Pipeline (each stage updates only when i_ce_pix = 1):
  - S1: register o_font_addr, px, in_box, hl = (hl_cnt[ch] != 0), and i_rgb.
  - S2: bit = i_font_bits[7-px].
    - Glyph pixel colour: 6'b110000 if hl, else 6'b111100.
    - Non-glyph in-box colour: 6'b000001.
    - o_active <= in_box.
  - Latency: 2 enabled pixels from (i_h, i_v) to the matching output.
  - The font ROM needs 1 clk. i_ce_pix is never high on two consecutive clks.
- Out of box: output 6'b000000 and o_active = 0 (but see Optional Feature).

Optional Feature:
- Macro: DEBUG_OVERLAY_BLEND_EN.
- Defined:
  - Out-of-box pixels pass the 2-stage-delayed i_rgb through unchanged.
  - Non-glyph in-box pixels show i_rgb with each 2-bit component shifted right by 1 (translucent box).
  - Glyph pixels are opaque.
- Undefined: out-of-box pixels are 0; the in-box background is the opaque 6'b000001. i_rgb is ignored; the port still exists.

Test Plan:
- Reset: hold i_rst_n = 0 while toggling i_ce_pix -> o_r/o_g/o_b/o_active = 0 and o_font_addr = 0 throughout. Release -> first valid output after 2 enabled pixels.
- Layout (NUM_CH = 2, DATA_W = 16, X0 = Y0 = 16):
  - Capture ch1 = 16'hA3F0 at a vblank rise.
  - Scan i_h = 16+8*k, i_v = 27 -> o_font_addr codes 31, 3A, 41, 33, 46, 30 in order, each with glyph row 3.
  - i_h = 63 is in box; i_h = 64 -> o_active = 0.
- Highlight (HILITE_FRAMES = 3): change ch0 from 0 to 1 and keep it stable -> ch0 glyphs are red (110000) for 3 frames after the change, yellow (111100) from the 4th. Unchanged channels stay yellow.
- Freeze: i_freeze = 1 across a vblank rise with new i_debug -> displayed digits and counters unchanged. Release -> next vblank captures the new value and the row highlights.
- Clock enable: i_ce_pix high every 4th clk, font model with 1-clk latency -> identical pixel stream to the every-2nd-clk case. Glyph bit7 maps to px = 0.
- Blend (macro defined): out-of-box i_rgb = 6'b101101 -> output 101101. Non-glyph in-box -> 010100. Glyph pixel -> 111100.

Source files
------------

// File: rtl/debug_hex_overlay_if.sv
// Pixel timing, capture, font-ROM and colour-output signals of debug_hex_overlay.
// slave = the overlay itself, master = whatever drives video and reads the result.
interface debug_hex_overlay_if #(
    parameter int NUM_CH = 8,
    parameter int DATA_W = 16
);
    logic                     i_ce_pix;
    logic [11:0]              i_h;
    logic [11:0]              i_v;
    logic                     i_vblank;
    logic                     i_freeze;
    logic [NUM_CH*DATA_W-1:0] i_debug;
    logic [5:0]               i_rgb;
    logic [10:0]              o_font_addr;
    logic [7:0]               i_font_bits;
    logic [1:0]               o_r;
    logic [1:0]               o_g;
    logic [1:0]               o_b;
    logic                     o_active;

    modport slave (
        input  i_ce_pix, i_h, i_v, i_vblank, i_freeze, i_debug, i_rgb, i_font_bits,
        output o_font_addr, o_r, o_g, o_b, o_active
    );

    modport master (
        output i_ce_pix, i_h, i_v, i_vblank, i_freeze, i_debug, i_rgb, i_font_bits,
        input  o_font_addr, o_r, o_g, o_b, o_active
    );
endinterface

// File: rtl/debug_hex_overlay.sv
// Hex text readout of NUM_CH debug channels with per-row change highlighting.
// Define DEBUG_OVERLAY_BLEND_EN to pass background video through and make the box translucent.
module debug_hex_overlay #(
    parameter int NUM_CH        = 8,
    parameter int DATA_W        = 16,
    parameter int X0            = 16,
    parameter int Y0            = 16,
    parameter int HILITE_FRAMES = 60
) (
    input  logic               clk,
    input  logic               i_rst_n,
    debug_hex_overlay_if.slave bus
);
    localparam int          DIGITS    = DATA_W / 4;
    localparam logic [11:0] X0_L      = 12'(X0);
    localparam logic [11:0] Y0_L      = 12'(Y0);
    localparam logic [11:0] BOX_W     = 12'((DIGITS + 2) * 8);
    localparam logic [11:0] BOX_H     = 12'(NUM_CH * 8);
    localparam logic [7:0]  HL_RELOAD = 8'(HILITE_FRAMES);
    localparam logic [5:0]  GLYPH_YEL = 6'b111100;
    localparam logic [5:0]  GLYPH_RED = 6'b110000;
    localparam logic [5:0]  BOX_BG    = 6'b000001;

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    logic [DATA_W-1:0] shadow [NUM_CH];
    logic [7:0]        hl_cnt [NUM_CH];
    logic              vblank_q;
    logic              frame_rise;

    assign frame_rise = bus.i_vblank & ~vblank_q;

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            vblank_q <= 1'b0;
            for (int c = 0; c < NUM_CH; c++) begin
                shadow[c] <= '0;
                hl_cnt[c] <= '0;
            end
        end else begin
            vblank_q <= bus.i_vblank;
            if (frame_rise && !bus.i_freeze) begin
                for (int c = 0; c < NUM_CH; c++) begin
                    shadow[c] <= bus.i_debug[c*DATA_W +: DATA_W];
                    if (bus.i_debug[c*DATA_W +: DATA_W] != shadow[c])
                        hl_cnt[c] <= HL_RELOAD;
                    else if (hl_cnt[c] != 8'd0)
                        hl_cnt[c] <= hl_cnt[c] - 8'd1;
                end
            end
        end
    end

    logic [11:0]       rx, ry;
    logic              in_box;
    logic [3:0]        ch;
    logic [8:0]        cc;
    logic [DATA_W-1:0] cur_val;
    logic              cur_hl;
    logic [3:0]        nib;
    logic [7:0]        code;

    always_comb begin
        rx      = bus.i_h - X0_L;
        ry      = bus.i_v - Y0_L;
        in_box  = (bus.i_h >= X0_L) && (rx < BOX_W) && (bus.i_v >= Y0_L) && (ry < BOX_H);
        ch      = ry[6:3];
        cc      = rx[11:3];
        cur_val = '0;
        cur_hl  = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (ch == 4'(c)) begin
                cur_val = shadow[c];
                cur_hl  = (hl_cnt[c] != 8'd0);
            end
        end
        // Column 2 shows the most significant nibble, the last column nibble 0.
        nib = '0;
        for (int d = 0; d < DIGITS; d++) begin
            if (cc == 9'(DIGITS + 1 - d))
                nib = cur_val[d*4 +: 4];
        end
        if (cc == 9'd0)
            code = hex_char(ch);
        else if (cc == 9'd1)
            code = 8'h3A;
        else
            code = hex_char(nib);
    end

    // S1: font address out, pixel context held until the glyph row returns
    logic [10:0] font_addr_p1;
    logic [2:0]  px_p1;
    logic        in_box_p1;
    logic        hl_p1;
    logic        vld_p1;

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            font_addr_p1 <= '0;
            px_p1        <= '0;
            in_box_p1    <= 1'b0;
            hl_p1        <= 1'b0;
            vld_p1       <= 1'b0;
        end else if (bus.i_ce_pix) begin
            font_addr_p1 <= {code, ry[2:0]};
            px_p1        <= rx[2:0];
            in_box_p1    <= in_box;
            hl_p1        <= cur_hl;
            vld_p1       <= 1'b1;
        end
    end

    assign bus.o_font_addr = font_addr_p1;

    logic       glyph;
    logic [5:0] colour;

    assign glyph = bus.i_font_bits[3'd7 - px_p1];

`ifdef DEBUG_OVERLAY_BLEND_EN
    logic [5:0] rgb_p1;

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n)
            rgb_p1 <= '0;
        else if (bus.i_ce_pix)
            rgb_p1 <= bus.i_rgb;
    end

    function automatic logic [5:0] pixel_colour(input logic box, input logic g,
                                                 input logic hl, input logic [5:0] bg);
        if (!box)
            return bg;
        if (g)
            return hl ? GLYPH_RED : GLYPH_YEL;
        return {1'b0, bg[5], 1'b0, bg[3], 1'b0, bg[1]};
    endfunction

    assign colour = pixel_colour(in_box_p1, glyph, hl_p1, rgb_p1);
`else
    function automatic logic [5:0] pixel_colour(input logic box, input logic g, input logic hl);
        if (!box)
            return 6'b000000;
        if (g)
            return hl ? GLYPH_RED : GLYPH_YEL;
        return BOX_BG;
    endfunction

    // Background video is not shown in this build; the port stays for pin compatibility.
    logic rgb_unused;
    assign rgb_unused = ^bus.i_rgb;
    assign colour     = pixel_colour(in_box_p1, glyph, hl_p1);
`endif

    // S2: final colour and box flag
    logic [5:0] rgb_p2;
    logic       active_p2;

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rgb_p2    <= '0;
            active_p2 <= 1'b0;
        end else if (bus.i_ce_pix) begin
            rgb_p2    <= vld_p1 ? colour : 6'b000000;
            active_p2 <= vld_p1 & in_box_p1;
        end
    end

    assign bus.o_r      = rgb_p2[5:4];
    assign bus.o_g      = rgb_p2[3:2];
    assign bus.o_b      = rgb_p2[1:0];
    assign bus.o_active = active_p2;
endmodule

// File: tb/tb_debug_hex_overlay.sv
// Scoreboard bench for debug_hex_overlay: 2 channels x 16 bits, box at (16,16), 3-frame highlight.
module tb_debug_hex_overlay;
    localparam int NUM_CH = 2;
    localparam int DATA_W = 16;
    localparam logic [5:0] YEL    = 6'b111100;
    localparam logic [5:0] RED    = 6'b110000;
    localparam logic [5:0] RGB_IN = 6'b101101;
`ifdef DEBUG_OVERLAY_BLEND_EN
    localparam logic [5:0] BG  = 6'b010100;
    localparam logic [5:0] OUT = 6'b101101;
`else
    localparam logic [5:0] BG  = 6'b000001;
    localparam logic [5:0] OUT = 6'b000000;
`endif

    typedef struct {
        int          id;
        bit          ca;
        logic [10:0] addr;
        logic        act;
        logic [5:0]  rgb;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks   = 0;
    int   failures = 0;
    int   div      = 2;
    int   pix_id   = 0;
    exp_t q[$];
    logic [7:0] scan_codes [6];

    always #5 clk = ~clk;

    debug_hex_overlay_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W)) bus ();

    debug_hex_overlay #(
        .NUM_CH(NUM_CH), .DATA_W(DATA_W), .X0(16), .Y0(16), .HILITE_FRAMES(3)
    ) dut (
        .clk(clk),
        .i_rst_n(rst_n),
        .bus(bus)
    );

    // Font ROM model: one clk latency; colon is blank, every other glyph row is 8'hA0.
    always @(posedge clk)
        bus.i_font_bits <= (bus.o_font_addr[10:3] == 8'h3A) ? 8'h00 : 8'hA0;

    task automatic chk(input string name, input int id, input logic [11:0] got, input logic [11:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s #%0d got=%h want=%h", name, id, got, want);
        end
    endtask

    task automatic pix(input int h, input int v, input bit ca, input logic [10:0] addr,
                       input logic act, input logic [5:0] rgb);
        exp_t e;
        repeat (div - 1) begin
            @(negedge clk);
            bus.i_ce_pix = 1'b0;
        end
        @(negedge clk);
        bus.i_h      = 12'(h);
        bus.i_v      = 12'(v);
        bus.i_ce_pix = 1'b1;
        e.id   = pix_id;
        e.ca   = ca;
        e.addr = addr;
        e.act  = act;
        e.rgb  = rgb;
        pix_id++;
        if (rst_n) q.push_back(e);
    endtask

    task automatic frame(input bit frz, input logic [31:0] dbg);
        @(negedge clk);
        bus.i_ce_pix = 1'b0;
        bus.i_freeze = frz;
        bus.i_debug  = dbg;
        bus.i_vblank = 1'b1;
        repeat (3) @(negedge clk);
        bus.i_vblank = 1'b0;
        bus.i_freeze = 1'b0;
        @(negedge clk);
    endtask

    task automatic scan_row(input logic [5:0] g);
        for (int k = 0; k < 6; k++)
            pix(16 + 8*k, 27, 1'b1, {scan_codes[k], 3'd3}, 1'b1, (k == 1) ? BG : g);
        pix(17, 27, 1'b1, {8'h31, 3'd3}, 1'b1, BG);
        pix(18, 27, 1'b1, {8'h31, 3'd3}, 1'b1, g);
        pix(63, 27, 1'b1, {8'h30, 3'd3}, 1'b1, BG);
        pix(64, 27, 1'b0, 11'h0, 1'b0, OUT);
    endtask

    // Monitor: address of pixel N is checked on its own enabled edge, its colour on the next one.
    initial begin
        exp_t e;
        exp_t prev;
        bit   have = 1'b0;
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                have = 1'b0;
            end else if (bus.i_ce_pix) begin
                #1;
                if (q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL scoreboard_empty got=0 want>0");
                end else begin
                    e = q.pop_front();
                    if (e.ca)
                        chk("font_addr", e.id, {1'b0, bus.o_font_addr}, {1'b0, e.addr});
                    if (have)
                        chk("pixel", prev.id, {5'b0, bus.o_active, bus.o_r, bus.o_g, bus.o_b},
                            {5'b0, prev.act, prev.rgb});
                    else
                        chk("warmup", e.id, {5'b0, bus.o_active, bus.o_r, bus.o_g, bus.o_b}, 12'h0);
                    prev = e;
                    have = 1'b1;
                end
            end
        end
    end

    initial begin
        #2000000;
        failures++;
        $display("FAIL watchdog got=timeout want=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        scan_codes   = '{8'h31, 8'h3A, 8'h41, 8'h33, 8'h46, 8'h30};
        bus.i_ce_pix = 1'b0;
        bus.i_h      = '0;
        bus.i_v      = '0;
        bus.i_vblank = 1'b0;
        bus.i_freeze = 1'b0;
        bus.i_debug  = '0;
        bus.i_rgb    = RGB_IN;

        // Reset held while the pixel enable keeps toggling
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus.i_ce_pix = 1'b1;
            bus.i_h      = 12'd20;
            bus.i_v      = 12'd20;
            @(negedge clk);
            bus.i_ce_pix = 1'b0;
            chk("rst_out", i, {5'b0, bus.o_active, bus.o_r, bus.o_g, bus.o_b}, 12'h0);
            chk("rst_addr", i, {1'b0, bus.o_font_addr}, 12'h0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        // Layout: ch1 = A3F0 just changed, so its glyphs are red
        frame(1'b0, {16'hA3F0, 16'h0000});
        scan_row(RED);
        pix(15, 27, 1'b0, 11'h0, 1'b0, OUT);
        pix(16, 16, 1'b1, {8'h30, 3'd0}, 1'b1, YEL);
        pix(32, 16, 1'b1, {8'h30, 3'd0}, 1'b1, YEL);
        pix(16, 31, 1'b1, {8'h31, 3'd7}, 1'b1, RED);
        pix(16, 32, 1'b0, 11'h0, 1'b0, OUT);
        pix(16, 15, 1'b0, 11'h0, 1'b0, OUT);

        // Highlight: ch0 0 -> 1, then stable
        frame(1'b0, {16'hA3F0, 16'h0001});
        pix(56, 16, 1'b1, {8'h31, 3'd0}, 1'b1, RED);
        pix(56, 24, 1'b1, {8'h30, 3'd0}, 1'b1, RED);
        frame(1'b0, {16'hA3F0, 16'h0001});
        pix(56, 16, 1'b1, {8'h31, 3'd0}, 1'b1, RED);
        frame(1'b0, {16'hA3F0, 16'h0001});
        pix(56, 16, 1'b1, {8'h31, 3'd0}, 1'b1, RED);
        pix(56, 24, 1'b1, {8'h30, 3'd0}, 1'b1, YEL);
        frame(1'b0, {16'hA3F0, 16'h0001});
        pix(56, 16, 1'b1, {8'h31, 3'd0}, 1'b1, YEL);

        // Freeze holds both value and counter
        frame(1'b1, {16'hA3F0, 16'h0005});
        pix(56, 16, 1'b1, {8'h31, 3'd0}, 1'b1, YEL);
        frame(1'b0, {16'hA3F0, 16'h0005});
        pix(56, 16, 1'b1, {8'h35, 3'd0}, 1'b1, RED);
        frame(1'b1, {16'hA3F0, 16'h0009});
        pix(56, 16, 1'b1, {8'h35, 3'd0}, 1'b1, RED);
        frame(1'b0, {16'hA3F0, 16'h0005});
        frame(1'b0, {16'hA3F0, 16'h0005});
        pix(56, 16, 1'b1, {8'h35, 3'd0}, 1'b1, RED);
        frame(1'b0, {16'hA3F0, 16'h0005});
        pix(56, 16, 1'b1, {8'h35, 3'd0}, 1'b1, YEL);

        // Same row at two enable rates
        div = 2;
        scan_row(YEL);
        div = 4;
        scan_row(YEL);
        div = 2;

        // Asynchronous reset mid-frame
        pix(56, 16, 1'b1, {8'h35, 3'd0}, 1'b1, YEL);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("midrst_out", 0, {5'b0, bus.o_active, bus.o_r, bus.o_g, bus.o_b}, 12'h0);
        chk("midrst_addr", 0, {1'b0, bus.o_font_addr}, 12'h0);
        @(negedge clk);
        bus.i_ce_pix = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        pix(56, 16, 1'b1, {8'h30, 3'd0}, 1'b1, YEL);
        pix(56, 24, 1'b1, {8'h30, 3'd0}, 1'b1, YEL);
        pix(0, 0, 1'b0, 11'h0, 1'b0, OUT);
        pix(0, 0, 1'b0, 11'h0, 1'b0, OUT);
        @(negedge clk);
        bus.i_ce_pix = 1'b0;
        repeat (2) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
